// File: rtl/hist_peak_finder_pkg.sv
// hist_peak_finder_pkg: shared histogram geometry defaults and peak-finder FSM state encoding
package hist_peak_finder_pkg;
    localparam int NB_DEF     = 4;
    localparam int PEAK_W_DEF = 8;
    localparam int BINS_DEF   = 16;
    localparam int PIXELS_DEF = 4;
    typedef enum logic [2:0] {IDLE, SCAN, DRAIN, OUT, DONE} state_t;
endpackage

// File: rtl/hist_max_tracker.sv
// hist_max_tracker: running max/argmax/sum over one pixel's bins; ports clk, res, clear, en, data, bin in; max_cnt, argmax, sum out
module hist_max_tracker #(
    parameter int NB     = 4,
    parameter int PEAK_W = 8,
    parameter int SUM_W  = PEAK_W + NB
) (
    input  logic              clk,
    input  logic              res,
    input  logic              clear,
    input  logic              en,
    input  logic [PEAK_W-1:0] data,
    input  logic [NB-1:0]     bin,
    output logic [PEAK_W-1:0] max_cnt,
    output logic [NB-1:0]     argmax,
    output logic [SUM_W-1:0]  sum
);
    always_ff @(posedge clk or posedge res) begin
        if (res || clear) begin
            max_cnt <= '0;
            argmax  <= '0;
            sum     <= '0;
        end else if (en) begin
            sum <= sum + SUM_W'(data);
            if (data > max_cnt) begin
                max_cnt <= data;
                argmax  <= bin;
            end
        end
    end
endmodule

// File: rtl/hist_peak_finder.sv
// hist_peak_finder: scans each pixel histogram after acquisition and reports argmax bin, max count, total count and hit
// ports: clk, res (async high), start, thresh | rd_en, rd_addr, rd_data | peak_valid/peak_ready, peak_pixel, peak_bin, peak_count, peak_sum, peak_hit | busy, done
module hist_peak_finder
    import hist_peak_finder_pkg::*;
#(
    parameter int NB     = NB_DEF,
    parameter int PEAK_W = PEAK_W_DEF,
    parameter int BINS   = BINS_DEF,
    parameter int PIXELS = PIXELS_DEF,
    parameter int ADDR_W = $clog2(BINS * PIXELS),
    parameter int SUM_W  = PEAK_W + NB,
    parameter int PIX_W  = $clog2(PIXELS)
) (
    input  logic              clk,
    input  logic              res,
    input  logic              start,
    input  logic [PEAK_W-1:0] thresh,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [PEAK_W-1:0] rd_data,
    output logic              peak_valid,
    input  logic              peak_ready,
    output logic [PIX_W-1:0]  peak_pixel,
    output logic [NB-1:0]     peak_bin,
    output logic [PEAK_W-1:0] peak_count,
    output logic [SUM_W-1:0]  peak_sum,
    output logic              peak_hit,
    output logic              busy,
    output logic              done
);
    state_t state, state_n;
    logic [PEAK_W-1:0] thr;
    logic [PIX_W-1:0] pix;
    logic [NB-1:0] bin, bin_d;
    logic vld_d, last_bin, last_pix, accept, scan_go, hit;
    logic [PEAK_W-1:0] max_cnt;
    logic [NB-1:0] argmax;
    logic [SUM_W-1:0] sum;
    always_comb begin
        last_bin = bin == NB'(BINS - 1);
        last_pix = pix == PIX_W'(PIXELS - 1);
        accept   = state == OUT && peak_ready;
        scan_go  = (state == IDLE && start) || (accept && !last_pix);
        state_n  = state == IDLE  ? (start ? SCAN : IDLE) :
                   state == SCAN  ? (last_bin ? DRAIN : SCAN) :
                   state == DRAIN ? OUT :
                   state == OUT   ? (peak_ready ? (last_pix ? DONE : SCAN) : OUT) : IDLE;
        hit        = max_cnt >= thr;
        busy       = state != IDLE;
        done       = state == DONE;
        peak_valid = state == OUT;
        peak_hit   = peak_valid && hit;
        peak_pixel = peak_valid ? pix : '0;
        peak_bin   = peak_valid ? (hit ? argmax : '1) : '0;
        peak_count = peak_valid ? max_cnt : '0;
        peak_sum   = peak_valid ? sum : '0;
    end
    always_ff @(posedge clk or posedge res) begin
        if (res) state <= IDLE;
        else state <= state_n;
    end
    // Addresses are contiguous across pixels, so rd_addr only ever increments after the start reset.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            thr     <= '0;
            pix     <= '0;
            bin     <= '0;
            bin_d   <= '0;
            vld_d   <= 1'b0;
            rd_en   <= 1'b0;
            rd_addr <= '0;
        end else begin
            vld_d <= rd_en;
            bin_d <= bin;
            if (state == IDLE && start) begin
                thr     <= thresh;
                pix     <= '0;
                rd_addr <= '0;
            end else if (accept && !last_pix) begin
                pix     <= pix + 1'b1;
                rd_addr <= rd_addr + 1'b1;
            end else if (state == SCAN && !last_bin) begin
                rd_addr <= rd_addr + 1'b1;
            end
            if (scan_go) begin
                rd_en <= 1'b1;
                bin   <= '0;
            end else if (state == SCAN) begin
                rd_en <= !last_bin;
                bin   <= last_bin ? bin : bin + 1'b1;
            end
        end
    end
    hist_max_tracker #(.NB(NB), .PEAK_W(PEAK_W), .SUM_W(SUM_W)) u_tracker (
        .clk    (clk),
        .res    (res),
        .clear  (scan_go),
        .en     (vld_d),
        .data   (rd_data),
        .bin    (bin_d),
        .max_cnt(max_cnt),
        .argmax (argmax),
        .sum    (sum)
    );
endmodule

// File: tb/tb_hist_peak_finder.sv
// tb_hist_peak_finder: directed checks of hist_peak_finder with a 64-entry histogram memory model
module tb_hist_peak_finder;
    logic        clk = 1'b0, res = 1'b1, start = 1'b0, peak_ready = 1'b0;
    logic [7:0]  thresh = '0, rd_data = '0, peak_count;
    logic        rd_en, peak_valid, peak_hit, busy, done;
    logic [5:0]  rd_addr;
    logic [1:0]  peak_pixel;
    logic [3:0]  peak_bin;
    logic [11:0] peak_sum;
    logic [7:0]  mem [64];
    logic [5:0]  rd_log [$];
    int total = 0, bad = 0;

    hist_peak_finder #(.NB(4), .PEAK_W(8), .BINS(16), .PIXELS(4)) dut (
        .clk(clk), .res(res), .start(start), .thresh(thresh),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .peak_valid(peak_valid), .peak_ready(peak_ready), .peak_pixel(peak_pixel),
        .peak_bin(peak_bin), .peak_count(peak_count), .peak_sum(peak_sum),
        .peak_hit(peak_hit), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) rd_data <= rd_en ? mem[rd_addr] : 8'h00;
    always @(posedge clk) if (rd_en) rd_log.push_back(rd_addr);

    function automatic logic [26:0] res_vec();
        return {peak_pixel, peak_bin, peak_count, peak_sum, peak_hit};
    endfunction

    task automatic do_start(input logic [7:0] t);
        @(negedge clk);
        thresh = t;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_valid(inout int n);
        while (!peak_valid && n < 80) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic accept();
        peak_ready = 1'b1;
        @(negedge clk);
        peak_ready = 1'b0;
    endtask

    task automatic test_reset();
        res = 1'b1;
        @(negedge clk);
        total++;
        if ({rd_en, rd_addr, peak_valid, done, busy, res_vec()} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got=%h want=0", {rd_en, rd_addr, peak_valid, done, busy, res_vec()});
        end
        res = 1'b0;
    endtask

    task automatic test_full_scan();
        int n;
        logic ok;
        rd_log.delete();
        do_start(8'd10);
        n = 1;
        wait_valid(n);
        total++;
        if (n !== 18) begin bad++; $display("FAIL first_valid_cycle got=%0d want=18", n); end
        total++;
        if (res_vec() !== {2'd0, 4'd9, 8'd200, 12'd311, 1'b1}) begin
            bad++; $display("FAIL pixel0_result got=%h want=%h", res_vec(), {2'd0, 4'd9, 8'd200, 12'd311, 1'b1});
        end
        ok = rd_log.size() == 16;
        for (int i = 0; i < 16 && ok; i++) ok = rd_log[i] == 6'(i);
        total++;
        if (!ok) begin bad++; $display("FAIL pixel0_read_seq got_len=%0d want_len=16", rd_log.size()); end
        rd_log.delete();
        accept();
        total++;
        if ({rd_en, rd_addr, peak_valid} !== {1'b1, 6'd16, 1'b0}) begin
            bad++; $display("FAIL pixel1_first_read got=%b/%0d want=1/16", rd_en, rd_addr);
        end
        n = 1;
        wait_valid(n);
        total++;
        if (n !== 18) begin bad++; $display("FAIL pixel1_valid_cycle got=%0d want=18", n); end
        total++;
        if (res_vec() !== {2'd1, 4'd3, 8'd77, 12'd259, 1'b1}) begin
            bad++; $display("FAIL pixel1_tie_result got=%h want=%h", res_vec(), {2'd1, 4'd3, 8'd77, 12'd259, 1'b1});
        end
        rd_log.delete();
        for (int i = 0; i < 7; i++) begin
            total++;
            if ({peak_valid, rd_en, res_vec()} !== {1'b1, 1'b0, 2'd1, 4'd3, 8'd77, 12'd259, 1'b1}) begin
                bad++; $display("FAIL stall_hold cycle=%0d got=%b/%b/%h want=1/0/%h", i, peak_valid, rd_en, res_vec(), {2'd1, 4'd3, 8'd77, 12'd259, 1'b1});
            end
            @(negedge clk);
        end
        total++;
        if (rd_log.size() !== 0) begin bad++; $display("FAIL stall_no_reads got=%0d want=0", rd_log.size()); end
        accept();
        total++;
        if ({rd_en, rd_addr, peak_valid} !== {1'b1, 6'd32, 1'b0}) begin
            bad++; $display("FAIL pixel2_first_read got=%b/%0d want=1/32", rd_en, rd_addr);
        end
        n = 1;
        wait_valid(n);
        total++;
        if (res_vec() !== {2'd2, 4'hF, 8'd5, 12'd80, 1'b0}) begin
            bad++; $display("FAIL pixel2_nohit got=%h want=%h", res_vec(), {2'd2, 4'hF, 8'd5, 12'd80, 1'b0});
        end
        accept();
        n = 1;
        wait_valid(n);
        total++;
        if (res_vec() !== {2'd3, 4'hF, 8'd0, 12'd0, 1'b0}) begin
            bad++; $display("FAIL pixel3_zero got=%h want=%h", res_vec(), {2'd3, 4'hF, 8'd0, 12'd0, 1'b0});
        end
        accept();
        total++;
        if ({done, busy} !== 2'b11) begin bad++; $display("FAIL done_pulse got=%b%b want=11", done, busy); end
        @(negedge clk);
        total++;
        if ({done, busy} !== 2'b00) begin bad++; $display("FAIL back_idle got=%b%b want=00", done, busy); end
    endtask

    task automatic test_back_to_back();
        int n, dcyc, bcyc;
        int vcyc [$];
        logic [26:0] p2, p3;
        peak_ready = 1'b1;
        do_start(8'd0);
        n = 1;
        dcyc = -1;
        bcyc = -1;
        p2 = '1;
        p3 = '1;
        while (n < 120 && bcyc < 0) begin
            if (peak_valid) begin
                vcyc.push_back(n);
                if (peak_pixel == 2'd2) p2 = res_vec();
                if (peak_pixel == 2'd3) p3 = res_vec();
            end
            if (done && dcyc < 0) dcyc = n;
            if (!busy && bcyc < 0) bcyc = n;
            @(negedge clk);
            n++;
        end
        peak_ready = 1'b0;
        total++;
        if (vcyc.size() != 4 || vcyc[0] != 18 || vcyc[1] != 36 || vcyc[2] != 54 || vcyc[3] != 72) begin
            bad++; $display("FAIL b2b_valid_cycles got=%p want=18,36,54,72", vcyc);
        end
        total++;
        if (dcyc !== 73 || bcyc !== 74) begin bad++; $display("FAIL b2b_done_busy got=%0d/%0d want=73/74", dcyc, bcyc); end
        total++;
        if (p2 !== {2'd2, 4'd0, 8'd5, 12'd80, 1'b1}) begin
            bad++; $display("FAIL b2b_flat_thresh0 got=%h want=%h", p2, {2'd2, 4'd0, 8'd5, 12'd80, 1'b1});
        end
        total++;
        if (p3 !== {2'd3, 4'd0, 8'd0, 12'd0, 1'b1}) begin
            bad++; $display("FAIL b2b_zero_thresh0 got=%h want=%h", p3, {2'd3, 4'd0, 8'd0, 12'd0, 1'b1});
        end
    endtask

    task automatic test_double_start();
        int n;
        logic ok;
        rd_log.delete();
        do_start(8'd10);
        repeat (4) @(negedge clk);
        thresh = 8'd255;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 6;
        wait_valid(n);
        total++;
        if (n !== 18) begin bad++; $display("FAIL dstart_valid_cycle got=%0d want=18", n); end
        ok = rd_log.size() == 16;
        for (int i = 0; i < 16 && ok; i++) ok = rd_log[i] == 6'(i);
        total++;
        if (!ok) begin bad++; $display("FAIL dstart_read_seq got_len=%0d want_len=16", rd_log.size()); end
        total++;
        if (res_vec() !== {2'd0, 4'd9, 8'd200, 12'd311, 1'b1}) begin
            bad++; $display("FAIL dstart_result got=%h want=%h", res_vec(), {2'd0, 4'd9, 8'd200, 12'd311, 1'b1});
        end
        res = 1'b1;
        @(negedge clk);
        res = 1'b0;
    endtask

    task automatic test_reset_mid_scan();
        int n;
        logic ok;
        peak_ready = 1'b1;
        do_start(8'd50);
        n = 1;
        while (!(rd_en && rd_addr == 6'd38) && n < 200) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (n !== 43) begin bad++; $display("FAIL midscan_reach got=%0d want=43", n); end
        #1 res = 1'b1;
        #1;
        total++;
        if ({rd_en, rd_addr, peak_valid, done, busy, res_vec()} !== '0) begin
            bad++; $display("FAIL midscan_reset got=%h want=0", {rd_en, rd_addr, peak_valid, done, busy, res_vec()});
        end
        @(negedge clk);
        res = 1'b0;
        peak_ready = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({peak_valid, busy, rd_en} !== 3'b000) begin
            bad++; $display("FAIL post_reset_idle got=%b want=000", {peak_valid, busy, rd_en});
        end
        rd_log.delete();
        do_start(8'd50);
        n = 1;
        wait_valid(n);
        ok = rd_log.size() == 16;
        for (int i = 0; i < 16 && ok; i++) ok = rd_log[i] == 6'(i);
        total++;
        if (!ok || n !== 18) begin bad++; $display("FAIL rescan_seq got_len=%0d cyc=%0d want_len=16 cyc=18", rd_log.size(), n); end
        total++;
        if (res_vec() !== {2'd0, 4'd9, 8'd200, 12'd311, 1'b1}) begin
            bad++; $display("FAIL rescan_result got=%h want=%h", res_vec(), {2'd0, 4'd9, 8'd200, 12'd311, 1'b1});
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            mem[i]      = 8'(i);
            mem[16 + i] = 8'(i);
            mem[32 + i] = 8'd5;
            mem[48 + i] = 8'd0;
        end
        mem[9]  = 8'd200;
        mem[19] = 8'd77;
        mem[28] = 8'd77;
        test_reset();
        test_full_scan();
        test_back_to_back();
        test_double_start();
        test_reset_mid_scan();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
